// File: rtl/tube_scan_ctrl.sv
// tube_scan_ctrl
//   Time-multiplexed scan controller for an 8-digit 7-segment tube.
//   A prescaler divides clk into one slot per digit; a 3-bit index walks
//   digits 0..7. The displayed value is swapped only at a frame boundary,
//   so a frame never mixes old and new digits.
// Parameters
//   DIV       clk cycles per digit slot (>= 2)
//   BLANK_LZ  1 = blank leading-zero digits (digit 0 always shown)
// Ports
//   clk, rst_n   clock (rising edge), synchronous active-low reset
//   data_in      32-bit hex value, nibble i -> digit i (digit 0 rightmost)
//   data_we      one-cycle write request for data_in
//   data_ack     one-cycle pulse once the requested value is on display
//   dig_en       per-digit enable, 0 forces the digit dark (sampled live)
//   dp_in        per-digit decimal point, 1 = lit (sampled live)
//   an           anode selects, active-low, at most one low
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low
//   frame_done   one-cycle pulse after the end of the digit 7 slot
module tube_scan_ctrl #(
  parameter int DIV      = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        data_we,
  output logic        data_ack,
  input  logic [7:0]  dig_en,
  input  logic [7:0]  dp_in,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] prescaler;
  logic [2:0]    idx;
  logic [31:0]   disp;
  logic [31:0]   shadow;
  logic          pending;

  logic          tick;
  logic          boundary;
  logic [7:0]    upper_zero;
  logic [3:0]    digit;
  logic          dark;
  logic [6:0]    hex_seg;
  logic [7:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  assign tick     = (prescaler == PRE_LAST);
  assign boundary = tick && (idx == 3'd7);
  assign digit    = disp[{idx, 2'b00} +: 4];

  // upper_zero[i]: every nibble from digit i upward is zero. Bit 0 stays
  // clear so the rightmost digit is never blanked.
  always_comb begin
    upper_zero = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      upper_zero[i] = ((disp >> (4 * i)) == '0);
    end
  end

  assign dark = !dig_en[idx] || (BLANK_LZ && upper_zero[idx]);

  always_comb begin
    hex_seg = 7'h7F;
    unique case (digit)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      4'hF: hex_seg = 7'h0E;
    endcase
  end

  always_comb begin
    an_nxt  = 8'hFF;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (!dark) begin
      an_nxt  = ~(8'h01 << idx);
      seg_nxt = hex_seg;
      dp_nxt  = ~dp_in[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler  <= '0;
      idx        <= '0;
      disp       <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      an         <= 8'hFF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      data_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      prescaler  <= tick ? '0 : prescaler + PW'(1);
      if (tick) begin
        idx <= idx + 3'd1;
      end
      frame_done <= boundary;
      data_ack   <= 1'b0;
      // A write landing on the boundary cycle bypasses the shadow and is
      // committed directly; it also supersedes any earlier pending write.
      if (boundary) begin
        pending <= 1'b0;
        if (data_we) begin
          disp     <= data_in;
          data_ack <= 1'b1;
        end else if (pending) begin
          disp     <= shadow;
          data_ack <= 1'b1;
        end
      end else if (data_we) begin
        shadow  <= data_in;
        pending <= 1'b1;
      end
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_tube_scan_ctrl.sv
module tb_tube_scan_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic        data_we;
  logic        data_ack;
  logic [7:0]  dig_en;
  logic [7:0]  dp_in;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  logic        data_ack0;
  logic [7:0]  an0;
  logic [6:0]  seg0;
  logic        dp0;
  logic        frame_done0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ack;
    logic       fd;
  } exp_t;

  exp_t sb[$];

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  tube_scan_ctrl #(.DIV(DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_we(data_we),
    .data_ack(data_ack), .dig_en(dig_en), .dp_in(dp_in), .an(an),
    .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  tube_scan_ctrl #(.DIV(DIV), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_we(data_we),
    .data_ack(data_ack0), .dig_en(dig_en), .dp_in(dp_in), .an(an0),
    .seg(seg0), .dp(dp0), .frame_done(frame_done0)
  );

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Reference model: at each edge, pushes the outputs the DUT must show
  // after that edge (derived from pre-edge state), then advances its state.
  task automatic model_loop();
    int          m_pre;
    int          m_idx;
    logic [31:0] m_disp;
    logic [31:0] m_shadow;
    logic        m_pend;
    logic [31:0] upper;
    logic        bnd;
    logic        drk;
    exp_t        e;
    m_pre = 0; m_idx = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, ack: 1'b0, fd: 1'b0};
        sb.push_back(e);
        m_pre = 0; m_idx = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
      end else begin
        bnd   = (m_pre == DIV - 1) && (m_idx == 7);
        upper = m_disp >> (4 * m_idx);
        drk   = !dig_en[m_idx] || (m_idx != 0 && upper == 32'h0);
        e.an  = drk ? 8'hFF : ~(8'h01 << m_idx);
        e.seg = drk ? 7'h7F : hex_tab[upper[3:0]];
        e.dp  = drk ? 1'b1 : ~dp_in[m_idx];
        e.ack = bnd && (data_we || m_pend);
        e.fd  = bnd;
        sb.push_back(e);
        if (bnd) begin
          if (data_we) m_disp = data_in;
          else if (m_pend) m_disp = m_shadow;
          m_pend = 1'b0;
        end else if (data_we) begin
          m_shadow = data_in;
          m_pend   = 1'b1;
        end
        if (m_pre == DIV - 1) begin
          m_pre = 0;
          m_idx = (m_idx + 1) % 8;
        end else begin
          m_pre = m_pre + 1;
        end
      end
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty t=%0t: no expected entry queued", $time);
      end else begin
        e = sb.pop_front();
        if (an !== e.an) begin
          errors++;
          $display("FAIL sb_an t=%0t got=%h expected=%h", $time, an, e.an);
        end
        checks++;
        if (seg !== e.seg) begin
          errors++;
          $display("FAIL sb_seg t=%0t got=%h expected=%h", $time, seg, e.seg);
        end
        checks++;
        if (dp !== e.dp) begin
          errors++;
          $display("FAIL sb_dp t=%0t got=%b expected=%b", $time, dp, e.dp);
        end
        checks++;
        if (data_ack !== e.ack) begin
          errors++;
          $display("FAIL sb_ack t=%0t got=%b expected=%b", $time, data_ack, e.ack);
        end
        checks++;
        if (frame_done !== e.fd) begin
          errors++;
          $display("FAIL sb_fd t=%0t got=%b expected=%b", $time, frame_done, e.fd);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_an0;
    logic [7:0] exp_an;
    rst_n = 1'b0; data_we = 1'b1; data_in = 32'hDEADBEEF; dig_en = 8'hFF; dp_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      checks++;
      if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || data_ack !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold got an=%h seg=%h dp=%b ack=%b expected FF 7F 1 0",
                 an, seg, dp, data_ack);
      end
    end
    rst_n = 1'b1; data_we = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      exp_an0 = (k <= 4) ? 8'hFE : 8'hFD;
      exp_an  = (k <= 4) ? 8'hFE : 8'hFF;
      checks++;
      if (an0 !== exp_an0 || an !== exp_an || data_ack !== 1'b0) begin
        errors++;
        $display("FAIL first_tick k=%0d got an0=%h an=%h ack=%b expected %h %h 0",
                 k, an0, an, data_ack, exp_an0, exp_an);
      end
    end
  endtask

  task automatic test_scan();
    int         got;
    logic [7:0] exp_an;
    data_in = 32'h76543210; data_we = 1'b1;
    cyc(1);
    data_we = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      cyc(1);
      if (data_ack === 1'b1) got = 1;
    end
    checks++;
    if (got == 0 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL scan_ack got ack_seen=%0d fd=%b expected 1 1", got, frame_done);
    end
    for (int k = 0; k < 32; k++) begin
      cyc(1);
      exp_an = ~(8'h01 << (k / 4));
      checks++;
      if (an !== exp_an) begin
        errors++;
        $display("FAIL scan_an k=%0d got=%h expected=%h", k, an, exp_an);
      end
      checks++;
      if (frame_done !== (k == 31)) begin
        errors++;
        $display("FAIL scan_fd k=%0d got=%b expected=%b", k, frame_done, k == 31);
      end
      if (k / 4 == 3) begin
        checks++;
        if (seg !== 7'h30) begin
          errors++;
          $display("FAIL scan_seg3 k=%0d got=%h expected=30", k, seg);
        end
      end
    end
  endtask

  task automatic test_handshake();
    int         wait_n;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    cyc(10);
    data_in = 32'h000000A5; data_we = 1'b1;
    cyc(1);
    data_we = 1'b0;
    wait_n = 0;
    for (int i = 1; i <= 40 && wait_n == 0; i++) begin
      cyc(1);
      if (data_ack === 1'b1) wait_n = i;
    end
    checks++;
    if (wait_n != 21 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL hs_ack_latency got=%0d fd=%b expected=21 1", wait_n, frame_done);
    end
    for (int k = 0; k < 32; k++) begin
      cyc(1);
      case (k / 4)
        0:       begin exp_an = 8'hFE; exp_seg = 7'h12; end
        1:       begin exp_an = 8'hFD; exp_seg = 7'h08; end
        default: begin exp_an = 8'hFF; exp_seg = 7'h7F; end
      endcase
      checks++;
      if (an !== exp_an || seg !== exp_seg || data_ack !== 1'b0) begin
        errors++;
        $display("FAIL hs_digits k=%0d got an=%h seg=%h ack=%b expected %h %h 0",
                 k, an, seg, data_ack, exp_an, exp_seg);
      end
      if (k / 4 == 2) begin
        checks++;
        if (an0 !== 8'hFB || seg0 !== 7'h40) begin
          errors++;
          $display("FAIL nolz_digit2 k=%0d got an0=%h seg0=%h expected FB 40", k, an0, seg0);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_align got fd=%b expected=1", frame_done);
    end
    cyc(5);
    data_in = 32'h2; data_we = 1'b1;
    cyc(1);
    data_we = 1'b0;
    cyc(25);
    data_in = 32'h1; data_we = 1'b1;
    cyc(1);
    data_we = 1'b0;
    checks++;
    if (data_ack !== 1'b1 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_commit got ack=%b fd=%b expected 1 1", data_ack, frame_done);
    end
    cyc(1);
    checks++;
    if (data_ack !== 1'b0 || an !== 8'hFE || seg !== 7'h79) begin
      errors++;
      $display("FAIL b2b_value got ack=%b an=%h seg=%h expected 0 FE 79", data_ack, an, seg);
    end
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (data_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL b2b_pending_cleared got acks=%0d expected=0", acks);
    end
  endtask

  task automatic test_mask_dp();
    int         got;
    logic [7:0] exp_an;
    data_in = 32'h76543210; data_we = 1'b1;
    cyc(1);
    data_we = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      cyc(1);
      if (data_ack === 1'b1) got = 1;
    end
    checks++;
    if (got == 0) begin
      errors++;
      $display("FAIL mask_ack got ack_seen=0 expected=1");
    end
    dig_en = 8'h0F; dp_in = 8'h01;
    for (int k = 0; k < 32; k++) begin
      cyc(1);
      exp_an = (k / 4 < 4) ? ~(8'h01 << (k / 4)) : 8'hFF;
      checks++;
      if (an !== exp_an || dp !== (k / 4 != 0)) begin
        errors++;
        $display("FAIL mask_dp k=%0d got an=%h dp=%b expected %h %b",
                 k, an, dp, exp_an, k / 4 != 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    int fe_cnt;
    dig_en = 8'hFF; dp_in = 8'h00;
    cyc(21);
    checks++;
    if (an !== 8'hDF) begin
      errors++;
      $display("FAIL rmid_align got an=%h expected=DF", an);
    end
    data_in = 32'hFFFFFFFF; data_we = 1'b1;
    cyc(1);
    data_we = 1'b0; rst_n = 1'b0;
    cyc(2);
    checks++;
    if (an !== 8'hFF || seg !== 7'h7F || data_ack !== 1'b0) begin
      errors++;
      $display("FAIL rmid_reset got an=%h seg=%h ack=%b expected FF 7F 0", an, seg, data_ack);
    end
    rst_n = 1'b1;
    acks = 0; fe_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      cyc(1);
      if (data_ack === 1'b1) acks++;
      if (k < 32 && an === 8'hFE) fe_cnt++;
      checks++;
      if (!(an === 8'hFF && seg === 7'h7F) && !(an === 8'hFE && seg === 7'h40)) begin
        errors++;
        $display("FAIL rmid_display k=%0d got an=%h seg=%h expected FF/7F or FE/40", k, an, seg);
      end
    end
    checks++;
    if (acks != 0 || fe_cnt != 4) begin
      errors++;
      $display("FAIL rmid_summary got acks=%0d fe_cycles=%0d expected 0 4", acks, fe_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; data_we = 1'b0; data_in = '0; dig_en = 8'hFF; dp_in = 8'h00;
    fork
      model_loop();
      monitor_loop();
    join_none
    test_reset();
    test_scan();
    test_handshake();
    test_back_to_back();
    test_mask_dp();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
